// File: rtl/vga_capture_wdma.sv
// vga_capture_wdma: Avalon-MM write-master DMA. Pops 16-bit pixel words
// from a show-ahead FIFO and writes them to consecutive frame-buffer
// addresses.
// Ports:
//   clk, reset (async, active-low)
//   avs_s1_*       : register slave (BASE, LENGTH, CONTROL, STATUS, COUNT), irq
//   fifo_read_*    : show-ahead FIFO read port (one-cycle pop strobe)
//   avm_write_*    : Avalon-MM write master, byte address, 16-bit data
module vga_capture_wdma #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned LEN_W  = 24,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avs_s1_chipselect,
  input  logic [2:0]        avs_s1_address,
  input  logic              avs_s1_read,
  input  logic              avs_s1_write,
  input  logic [31:0]       avs_s1_writedata,
  input  logic [3:0]        avs_s1_byteenable,
  output logic [31:0]       avs_s1_readdata,
  output logic              avs_s1_waitrequest,
  output logic              avs_s1_irq,
  output logic              fifo_read_read,
  input  logic [DATA_W-1:0] fifo_read_data,
  input  logic              fifo_read_empty,
  output logic [ADDR_W-1:0] avm_write_address,
  output logic              avm_write_write,
  output logic [DATA_W-1:0] avm_write_writedata,
  input  logic              avm_write_waitrequest
);

  localparam int unsigned REG_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WRITE, S_FIN} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]    length_q, length_d;
  logic                irq_en_q, irq_en_d;
  logic                cont_q, cont_d;
  logic                done_q, done_d;
  logic [LEN_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    remain_q, remain_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                pop_c;
  logic                reg_wr_c;
  logic                go_c;
  logic                busy_c;

  // Byte-lane merge of a register write into the current value.
  function automatic logic [REG_W-1:0] merge_be(input logic [REG_W-1:0] old_v,
                                                input logic [REG_W-1:0] new_v,
                                                input logic [3:0]       be);
    logic [REG_W-1:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
    end
    return r;
  endfunction

  assign reg_wr_c = avs_s1_chipselect && avs_s1_write;
  assign go_c     = reg_wr_c && (avs_s1_address == 3'd2) &&
                    avs_s1_byteenable[0] && avs_s1_writedata[0];
  assign busy_c   = (state_q != S_IDLE);

  // Register file updates followed by the transfer FSM (FSM DONE set wins over a clear).
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    length_d = length_q;
    irq_en_d = irq_en_q;
    cont_d   = cont_q;
    done_d   = done_q;
    count_d  = count_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    pop_c    = 1'b0;

    if (reg_wr_c) begin
      case (avs_s1_address)
        3'd0: base_d = ADDR_W'(merge_be(REG_W'(base_q), avs_s1_writedata,
                                        avs_s1_byteenable)) & ~ADDR_W'(1);
        3'd1: length_d = LEN_W'(merge_be(REG_W'(length_q), avs_s1_writedata,
                                         avs_s1_byteenable));
        3'd2: if (avs_s1_byteenable[0]) begin
                irq_en_d = avs_s1_writedata[1];
                cont_d   = avs_s1_writedata[2];
              end
        3'd3: if (avs_s1_byteenable[0] && avs_s1_writedata[1]) done_d = 1'b0;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (go_c) begin
          if (length_q != '0) begin
            addr_d   = base_q;
            remain_d = length_q;
            count_d  = '0;
            state_d  = S_FETCH;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_FETCH: begin
        // Show-ahead head is captured and popped in the same cycle.
        if (!fifo_read_empty) begin
          wdata_d = fifo_read_data;
          pop_c   = 1'b1;
          wr_d    = 1'b1;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (!avm_write_waitrequest) begin
          wr_d     = 1'b0;
          addr_d   = addr_q + ADDR_W'(2);
          count_d  = count_q + LEN_W'(1);
          remain_d = remain_q - LEN_W'(1);
          state_d  = (remain_q == LEN_W'(1)) ? S_FIN : S_FETCH;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (cont_q && (length_q != '0)) begin
          addr_d   = base_q;
          remain_d = length_q;
          count_d  = '0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      length_q <= '0;
      irq_en_q <= 1'b0;
      cont_q   <= 1'b0;
      done_q   <= 1'b0;
      count_q  <= '0;
      addr_q   <= '0;
      remain_q <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      length_q <= length_d;
      irq_en_q <= irq_en_d;
      cont_q   <= cont_d;
      done_q   <= done_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Zero-latency register read mux.
  always_comb begin
    avs_s1_readdata = '0;
    if (avs_s1_chipselect && avs_s1_read) begin
      case (avs_s1_address)
        3'd0: avs_s1_readdata = REG_W'(base_q);
        3'd1: avs_s1_readdata = REG_W'(length_q);
        3'd2: avs_s1_readdata = REG_W'({cont_q, irq_en_q, 1'b0});
        3'd3: avs_s1_readdata = REG_W'({done_q, busy_c});
        3'd4: avs_s1_readdata = REG_W'(count_q);
        default: avs_s1_readdata = '0;
      endcase
    end
  end

  assign avs_s1_waitrequest  = 1'b0;
  assign avs_s1_irq          = done_q && irq_en_q;
  assign fifo_read_read      = pop_c;
  assign avm_write_address   = addr_q;
  assign avm_write_write     = wr_q;
  assign avm_write_writedata = wdata_q;

endmodule

// File: tb/tb_vga_capture_wdma.sv
// tb_vga_capture_wdma: directed self-checking bench for vga_capture_wdma.
// Models a 64-entry show-ahead FIFO, a write slave with programmable wait
// states, and logs every accepted write for comparison.
module tb_vga_capture_wdma;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned LEN_W  = 24;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cs, rd, wr;
  logic [2:0]        reg_addr;
  logic [31:0]       reg_wdata;
  logic [3:0]        reg_be;
  logic [31:0]       readdata;
  logic              s_wait, irq;
  logic              fifo_read_read;
  logic [DATA_W-1:0] fifo_read_data;
  logic              fifo_read_empty;
  logic [ADDR_W-1:0] avm_write_address;
  logic              avm_write_write;
  logic [DATA_W-1:0] avm_write_writedata;
  logic              avm_write_waitrequest;

  always #5 clk = ~clk;

  vga_capture_wdma #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .DATA_W(DATA_W)) dut (
    .clk                   (clk),
    .reset                 (rst_n),
    .avs_s1_chipselect     (cs),
    .avs_s1_address        (reg_addr),
    .avs_s1_read           (rd),
    .avs_s1_write          (wr),
    .avs_s1_writedata      (reg_wdata),
    .avs_s1_byteenable     (reg_be),
    .avs_s1_readdata       (readdata),
    .avs_s1_waitrequest    (s_wait),
    .avs_s1_irq            (irq),
    .fifo_read_read        (fifo_read_read),
    .fifo_read_data        (fifo_read_data),
    .fifo_read_empty       (fifo_read_empty),
    .avm_write_address     (avm_write_address),
    .avm_write_write       (avm_write_write),
    .avm_write_writedata   (avm_write_writedata),
    .avm_write_waitrequest (avm_write_waitrequest)
  );

  // FIFO model: stimulus writes mem/wp, the monitor advances rp.
  logic [15:0] fifo_mem [0:63];
  logic [5:0]  wp = '0;
  logic [5:0]  rp = '0;
  assign fifo_read_empty = (rp == wp);
  assign fifo_read_data  = fifo_mem[rp];

  // Write slave model and accepted-write log.
  int unsigned wait_n    = 0;
  int unsigned stall_cnt = 0;
  int unsigned stalls    = 0;
  int unsigned unstable  = 0;
  int unsigned pop_bad   = 0;
  logic        held_q    = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [15:0] prev_data = '0;
  logic [31:0] log_addr [0:63];
  logic [15:0] log_data [0:63];
  logic [5:0]  log_n = '0;

  assign avm_write_waitrequest = avm_write_write && (stall_cnt < wait_n);

  always @(posedge clk) begin
    if (fifo_read_read) begin
      if (fifo_read_empty) pop_bad <= pop_bad + 1;
      else rp <= rp + 6'd1;
    end
    if (avm_write_write) begin
      if (held_q && (avm_write_address != prev_addr || avm_write_writedata != prev_data))
        unstable <= unstable + 1;
      if (avm_write_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
        stalls    <= stalls + 1;
      end else begin
        stall_cnt       <= 0;
        log_addr[log_n] <= avm_write_address;
        log_data[log_n] <= avm_write_writedata;
        log_n           <= log_n + 6'd1;
      end
    end
    held_q    <= avm_write_write && avm_write_waitrequest;
    prev_addr <= avm_write_address;
    prev_data <= avm_write_writedata;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [15:0] w);
    fifo_mem[wp] = w;
    wp = wp + 6'd1;
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [31:0] d,
                        input logic [3:0] be = 4'hF);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; reg_addr = a; reg_wdata = d; reg_be = be;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; reg_be = 4'h0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; reg_addr = a;
    #1 d = readdata;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    logic [31:0] s;
    s = 32'h1;
    for (int i = 0; i < budget && s[0]; i++) reg_rd(3'd3, s);
    check(tag, {31'b0, s[0]}, 32'h0);
  endtask

  task automatic wait_log(input string tag, input logic [5:0] n, input int budget);
    for (int i = 0; i < budget && log_n < n; i++) @(negedge clk);
    check(tag, 32'(log_n), 32'(n));
  endtask

  task automatic check_log(input string tag, input int idx,
                           input logic [31:0] a, input logic [15:0] d);
    check({tag, " addr"}, log_addr[idx], a);
    check({tag, " data"}, 32'(log_data[idx]), 32'(d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    rst_n = 1'b0; cs = 1'b0; rd = 1'b0; wr = 1'b0;
    reg_addr = '0; reg_wdata = '0; reg_be = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    for (int i = 0; i < 8; i++) begin
      reg_rd(3'(i), v);
      check($sformatf("reset reg%0d", i), v, 32'h0);
    end
    check("reset irq", {31'b0, irq}, 32'h0);
    check("reset write", {31'b0, avm_write_write}, 32'h0);
    check("reset pop", {31'b0, fifo_read_read}, 32'h0);
    check("reset address", avm_write_address, 32'h0);

    // Byte lanes and bit0 of BASE, LENGTH width
    reg_wr(3'd0, 32'h1234_5679);
    reg_rd(3'd0, v); check("base bit0", v, 32'h1234_5678);
    reg_wr(3'd0, 32'h0000_AB00, 4'b0010);
    reg_rd(3'd0, v); check("base byte lane", v, 32'h1234_AB78);
    reg_wr(3'd1, 32'hFFFF_FFFF);
    reg_rd(3'd1, v); check("length width", v, 32'h00FF_FFFF);
    reg_wr(3'd5, 32'hFFFF_FFFF);
    reg_rd(3'd5, v); check("reg5 reads 0", v, 32'h0);

    // Basic 4-word transfer, no wait states
    for (int i = 0; i < 4; i++) push(16'hA001 + 16'(i));
    reg_wr(3'd0, 32'h1000);
    reg_wr(3'd1, 32'd4);
    reg_wr(3'd2, 32'h3);
    wait_idle("basic busy", 100);
    check("basic writes", 32'(log_n), 32'd4);
    for (int i = 0; i < 4; i++)
      check_log($sformatf("basic w%0d", i), i, 32'h1000 + 32'(2*i), 16'hA001 + 16'(i));
    check("basic pops", 32'(rp), 32'd4);
    reg_rd(3'd3, v); check("basic status", v, 32'h2);
    reg_rd(3'd4, v); check("basic count", v, 32'd4);
    reg_rd(3'd2, v); check("control reads", v, 32'h2);
    check("basic irq", {31'b0, irq}, 32'h1);
    reg_wr(3'd3, 32'h2);
    check("irq cleared", {31'b0, irq}, 32'h0);
    reg_rd(3'd3, v); check("done cleared", v, 32'h0);

    // Same transfer with 3 wait states per write
    wait_n = 3;
    for (int i = 0; i < 4; i++) push(16'hA011 + 16'(i));
    reg_wr(3'd2, 32'h1);
    wait_idle("wait busy", 200);
    check("wait writes", 32'(log_n), 32'd8);
    for (int i = 0; i < 4; i++)
      check_log($sformatf("wait w%0d", i), 4 + i, 32'h1000 + 32'(2*i), 16'hA011 + 16'(i));
    check("wait stalls", stalls, 32'd12);
    check("wait stable", unstable, 32'd0);
    check("wait pops", 32'(rp), 32'd8);
    check("irq masked", {31'b0, irq}, 32'h0);
    wait_n = 0;
    reg_wr(3'd3, 32'h2);

    // FIFO runs dry after two words
    push(16'hB001); push(16'hB002);
    reg_wr(3'd2, 32'h1);
    repeat (15) @(negedge clk);
    check("gap writes", 32'(log_n), 32'd10);
    check("gap no write", {31'b0, avm_write_write}, 32'h0);
    check("gap pops", 32'(rp), 32'd10);
    reg_rd(3'd3, v); check("gap busy", v, 32'h1);
    reg_rd(3'd4, v); check("gap count", v, 32'd2);
    push(16'hB003); push(16'hB004);
    wait_idle("gap busy end", 100);
    check("gap total", 32'(log_n), 32'd12);
    for (int i = 0; i < 4; i++)
      check_log($sformatf("gap w%0d", i), 8 + i, 32'h1000 + 32'(2*i), 16'hB001 + 16'(i));
    reg_wr(3'd3, 32'h2);

    // Zero length GO
    reg_wr(3'd1, 32'd0);
    reg_wr(3'd2, 32'h1);
    reg_rd(3'd3, v); check("len0 status", v, 32'h2);
    repeat (5) @(negedge clk);
    check("len0 writes", 32'(log_n), 32'd12);
    reg_wr(3'd3, 32'h2);

    // GO while busy is ignored
    reg_wr(3'd1, 32'd3);
    reg_wr(3'd0, 32'h5000);
    reg_wr(3'd2, 32'h1);
    push(16'hC001);
    wait_log("busy go first", 6'd13, 50);
    reg_wr(3'd2, 32'h1);
    reg_rd(3'd4, v); check("busy go count", v, 32'd1);
    push(16'hC002); push(16'hC003);
    wait_idle("busy go end", 100);
    check("busy go writes", 32'(log_n), 32'd15);
    for (int i = 0; i < 3; i++)
      check_log($sformatf("busy go w%0d", i), 12 + i, 32'h5000 + 32'(2*i), 16'hC001 + 16'(i));
    reg_rd(3'd4, v); check("busy go final count", v, 32'd3);
    reg_wr(3'd3, 32'h2);

    // Continuous mode, BASE change, then stop
    reg_wr(3'd0, 32'h2000);
    reg_wr(3'd1, 32'd2);
    for (int i = 0; i < 4; i++) push(16'hD001 + 16'(i));
    reg_wr(3'd2, 32'h5);
    wait_log("cont p12", 6'd19, 100);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      check_log($sformatf("cont w%0d", i), 15 + i, 32'h2000 + 32'(2*(i%2)), 16'hD001 + 16'(i));
    reg_wr(3'd0, 32'h3000);
    push(16'hD005); push(16'hD006);
    wait_log("cont p3", 6'd21, 100);
    repeat (3) @(negedge clk);
    check("cont p3 a0", log_addr[19], 32'h2000);
    check("cont p3 a1", log_addr[20], 32'h2002);
    push(16'hD007); push(16'hD008);
    wait_log("cont p4", 6'd23, 100);
    repeat (3) @(negedge clk);
    check_log("cont p4 w0", 21, 32'h3000, 16'hD007);
    check_log("cont p4 w1", 22, 32'h3002, 16'hD008);
    reg_wr(3'd2, 32'h0);
    push(16'hD009); push(16'hD00A);
    wait_idle("cont stop", 100);
    check("cont stop writes", 32'(log_n), 32'd25);
    check("cont p5 a0", log_addr[23], 32'h3000);
    check("cont p5 a1", log_addr[24], 32'h3002);
    push(16'hD00B);
    repeat (10) @(negedge clk);
    check("idle no writes", 32'(log_n), 32'd25);
    check("idle no pop", 32'(rp), 32'd25);
    check("pop when empty", pop_bad, 32'd0);

    // Reset in the middle of a stalled write
    wait_n = 50;
    reg_wr(3'd3, 32'h2);
    reg_wr(3'd0, 32'h6000);
    reg_wr(3'd1, 32'd1);
    reg_wr(3'd2, 32'h1);
    for (int i = 0; i < 20 && !avm_write_write; i++) @(negedge clk);
    check("midwrite asserted", {31'b0, avm_write_write}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("reset drops write", {31'b0, avm_write_write}, 32'h0);
    check("reset address", avm_write_address, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    reg_rd(3'd3, v); check("reset busy", v, 32'h0);
    reg_rd(3'd0, v); check("reset base", v, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
